// File: rtl/bram_bus_pkg.sv
// Shared definitions for BRAM bus initiators: FSM states, bus constants and
// word-alignment helper.
package bram_bus_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_CAP  = 3'd2,
      ST_WR   = 3'd3,
      ST_FILL = 3'd4,
      ST_FIN  = 3'd5
   } state_t;

   localparam logic [31:0] WORD_BYTES      = 32'd4;
   localparam logic        MODE_COPY       = 1'b0;
   localparam logic        MODE_FILL       = 1'b1;
   localparam logic [3:0]  WMASK_FULL      = 4'hF;
   localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & WORD_ALIGN_MASK;
   endfunction

endpackage

// File: rtl/bram_dma.sv
// Single-command BRAM DMA initiator: word copy (read/capture/write per word)
// or pattern fill (one write per word), with abort at safe points.
module bram_dma
   import bram_bus_pkg::*;
#(
   parameter int LEN_W  = 16,
   parameter int RD_LAT = 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic             mode,
   input  logic [31:0]      src_addr,
   input  logic [31:0]      dst_addr,
   input  logic [LEN_W-1:0] len,
   input  logic [31:0]      pattern,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic [LEN_W-1:0] words_done,
   output logic             cs,
   output logic             rd,
   output logic             wr,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   output logic [3:0]       mem_wmask,
   input  logic [31:0]      mem_rdata
);

   generate
      if (RD_LAT != 1) begin : g_bad_rd_lat
         $error("bram_dma supports RD_LAT == 1 only");
      end
   endgenerate

   localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
   localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

   state_t           state_r, state_s;
   logic [31:0]      src_r, src_s;
   logic [31:0]      dst_r, dst_s;
   logic [LEN_W-1:0] rem_r, rem_s;
   logic [LEN_W-1:0] wd_r, wd_s;
   logic [31:0]      pat_r, pat_s;
   logic             aborted_r, aborted_s;
   logic             busy_r, busy_s;
   logic             done_r, done_s;
   logic             cs_r, cs_s;
   logic             rd_r, rd_s;
   logic             wr_r, wr_s;
   logic [31:0]      addr_r, addr_s;
   logic [31:0]      wdata_r, wdata_s;
   logic [3:0]       wmask_r, wmask_s;

   // State and datapath registers; reset releases the bus immediately.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r   <= ST_IDLE;
         src_r     <= 32'd0;
         dst_r     <= 32'd0;
         rem_r     <= LEN_ZERO;
         wd_r      <= LEN_ZERO;
         pat_r     <= 32'd0;
         aborted_r <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         cs_r      <= 1'b0;
         rd_r      <= 1'b0;
         wr_r      <= 1'b0;
         addr_r    <= 32'd0;
         wdata_r   <= 32'd0;
         wmask_r   <= 4'h0;
      end else begin
         state_r   <= state_s;
         src_r     <= src_s;
         dst_r     <= dst_s;
         rem_r     <= rem_s;
         wd_r      <= wd_s;
         pat_r     <= pat_s;
         aborted_r <= aborted_s;
         busy_r    <= busy_s;
         done_r    <= done_s;
         cs_r      <= cs_s;
         rd_r      <= rd_s;
         wr_r      <= wr_s;
         addr_r    <= addr_s;
         wdata_r   <= wdata_s;
         wmask_r   <= wmask_s;
      end
   end

   // Next-state and counter update; the copy/fill mode is carried by the state.
   always_comb begin
      state_s   = state_r;
      src_s     = src_r;
      dst_s     = dst_r;
      rem_s     = rem_r;
      wd_s      = wd_r;
      pat_s     = pat_r;
      aborted_s = aborted_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               src_s     = word_align(src_addr);
               dst_s     = word_align(dst_addr);
               rem_s     = len;
               pat_s     = pattern;
               wd_s      = LEN_ZERO;
               aborted_s = 1'b0;
               if (len == LEN_ZERO) begin
                  state_s = ST_FIN;
               end else if (mode == MODE_FILL) begin
                  state_s = ST_FILL;
               end else begin
                  state_s = ST_RD;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RD, ST_CAP: begin
            if (abort) begin
               state_s   = ST_FIN;
               aborted_s = 1'b1;
            end else if (state_r == ST_RD) begin
               state_s = ST_CAP;
            end else begin
               state_s = ST_WR;
            end
         end
         ST_WR, ST_FILL: begin
            // The write in flight always completes, so counters advance first.
            src_s = src_r + WORD_BYTES;
            dst_s = dst_r + WORD_BYTES;
            rem_s = rem_r - LEN_ONE;
            wd_s  = wd_r + LEN_ONE;
            if (abort) begin
               state_s   = ST_FIN;
               aborted_s = 1'b1;
            end else if (rem_r == LEN_ONE) begin
               state_s = ST_FIN;
            end else if (state_r == ST_WR) begin
               state_s = ST_RD;
            end else begin
               state_s = ST_FILL;
            end
         end
         ST_FIN: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Bus outputs decoded from the next state so they register in step with it.
   always_comb begin
      busy_s  = (state_s != ST_IDLE);
      done_s  = 1'b0;
      cs_s    = 1'b0;
      rd_s    = 1'b0;
      wr_s    = 1'b0;
      addr_s  = addr_r;
      wdata_s = wdata_r;
      wmask_s = 4'h0;
      case (state_s)
         ST_RD: begin
            cs_s   = 1'b1;
            rd_s   = 1'b1;
            addr_s = src_s;
         end
         ST_WR: begin
            cs_s    = 1'b1;
            wr_s    = 1'b1;
            addr_s  = dst_s;
            wdata_s = mem_rdata;
            wmask_s = WMASK_FULL;
         end
         ST_FILL: begin
            cs_s    = 1'b1;
            wr_s    = 1'b1;
            addr_s  = dst_s;
            wdata_s = pat_s;
            wmask_s = WMASK_FULL;
         end
         ST_FIN: begin
            done_s = 1'b1;
         end
         default: begin
            done_s = 1'b0;
         end
      endcase
   end

   assign busy       = busy_r;
   assign done       = done_r;
   assign aborted    = aborted_r;
   assign words_done = wd_r;
   assign cs         = cs_r;
   assign rd         = rd_r;
   assign wr         = wr_r;
   assign mem_addr   = addr_r;
   assign mem_wdata  = wdata_r;
   assign mem_wmask  = wmask_r;

endmodule

// File: tb/tb_bram_dma.sv
// Bench for bram_dma: a per-cycle expectation trace built from the command
// rules, a BRAM responder, and literal checks pinning that trace.
module tb_bram_dma;
   localparam int LEN_W = 16;

   logic             clk = 1'b0;
   logic             resetn = 1'b0;
   logic             start = 1'b0;
   logic             mode = 1'b0;
   logic             abort = 1'b0;
   logic [31:0]      src_addr = 32'd0;
   logic [31:0]      dst_addr = 32'd0;
   logic [31:0]      pattern = 32'd0;
   logic [LEN_W-1:0] len = 16'd0;
   logic [31:0]      mem_rdata = 32'd0;
   logic             busy, done, aborted, cs, rd, wr;
   logic [LEN_W-1:0] words_done;
   logic [31:0]      mem_addr, mem_wdata;
   logic [3:0]       mem_wmask;

   always #5 clk = ~clk;

   bram_dma #(.LEN_W(LEN_W), .RD_LAT(1)) dut (
      .clk(clk), .resetn(resetn), .start(start), .mode(mode),
      .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .pattern(pattern),
      .abort(abort), .busy(busy), .done(done), .aborted(aborted),
      .words_done(words_done), .cs(cs), .rd(rd), .wr(wr),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_rdata(mem_rdata)
   );

   typedef struct {
      logic             busy, done, aborted, cs, rd, wr;
      logic [31:0]      addr, wdata;
      logic [LEN_W-1:0] wd;
   } rec_t;

   logic [31:0] ram [0:63];
   logic [31:0] mdl [0:63];
   rec_t        exp_q [$];
   int          tests = 0;
   int          fails = 0;
   bit          check_en = 1'b0;
   int          cyc = 0;
   int          done_cyc = -1;
   int          wr_cnt = 0;
   int          cs_cnt = 0;
   bit          first_seen = 1'b0;
   logic [31:0] first_wr_addr = 32'd0;
   int          m_wd = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
      end
   endtask

   function automatic rec_t blank();
      rec_t r;
      r.busy = 1'b0; r.done = 1'b0; r.aborted = 1'b0;
      r.cs = 1'b0; r.rd = 1'b0; r.wr = 1'b0;
      r.addr = 32'd0; r.wdata = 32'd0; r.wd = 16'd0;
      return r;
   endfunction

   // Responder: full-word writes, one-cycle registered reads.
   initial forever begin
      @(posedge clk);
      if (cs && wr) ram[mem_addr[7:2]] = mem_wdata;
      if (cs && rd) mem_rdata <= ram[mem_addr[7:2]];
   end

   // Compare process: checks every cycle against the planned trace.
   initial forever begin
      rec_t e;
      @(negedge clk);
      if (check_en) begin
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("busy", 32'(busy), 32'(e.busy));
            chk("done", 32'(done), 32'(e.done));
            chk("cs", 32'(cs), 32'(e.cs));
            chk("rd", 32'(rd), 32'(e.rd));
            chk("wr", 32'(wr), 32'(e.wr));
            chk("wmask", 32'(mem_wmask), e.wr ? 32'hF : 32'h0);
            chk("words_done", 32'(words_done), 32'(e.wd));
            if (e.cs) chk("mem_addr", mem_addr, e.addr);
            if (e.wr) chk("mem_wdata", mem_wdata, e.wdata);
            if (e.done) chk("aborted", 32'(aborted), 32'(e.aborted));
         end else begin
            chk("idle_cs", 32'(cs), 32'h0);
            chk("idle_done", 32'(done), 32'h0);
         end
      end
      if (cs) cs_cnt++;
      if (cs && wr) begin
         wr_cnt++;
         if (!first_seen) first_wr_addr = mem_addr;
         first_seen = 1'b1;
      end
      if (done) done_cyc = cyc;
      cyc++;
   end

   // Build the expected per-cycle trace of one command from its word rules.
   task automatic plan(input bit m, input logic [31:0] s, input logic [31:0] d,
                       input int n, input logic [31:0] p, input int abort_at);
      rec_t        r;
      int          c, w;
      bit          stop;
      logic [31:0] sa, da, a;
      sa = s & 32'hFFFF_FFFC;
      da = d & 32'hFFFF_FFFC;
      r = blank(); r.wd = 16'(m_wd); exp_q.push_back(r);
      c = 1; w = 0; stop = 1'b0;
      while (w < n && !stop) begin
         if (!m) begin
            r = blank(); r.busy = 1'b1; r.cs = 1'b1; r.rd = 1'b1;
            r.addr = sa + 32'(4 * w); r.wd = 16'(w);
            exp_q.push_back(r);
            if (abort_at == c) stop = 1'b1;
            c++;
            if (!stop) begin
               r = blank(); r.busy = 1'b1; r.wd = 16'(w);
               exp_q.push_back(r);
               if (abort_at == c) stop = 1'b1;
               c++;
            end
         end
         if (!stop) begin
            r = blank(); r.busy = 1'b1; r.cs = 1'b1; r.wr = 1'b1;
            r.addr = da + 32'(4 * w); r.wd = 16'(w);
            a = sa + 32'(4 * w);
            r.wdata = m ? p : mdl[a[7:2]];
            mdl[r.addr[7:2]] = r.wdata;
            exp_q.push_back(r);
            if (abort_at == c) stop = 1'b1;
            c++;
            w++;
         end
      end
      r = blank(); r.busy = 1'b1; r.done = 1'b1; r.aborted = stop; r.wd = 16'(w);
      exp_q.push_back(r);
      m_wd = w;
   endtask

   // Issue one command and run it to completion; optional abort and mid-command start.
   task automatic issue(input bit m, input logic [31:0] s, input logic [31:0] d,
                        input int n, input logic [31:0] p, input int abort_at,
                        input int restart_at);
      @(posedge clk); #2;
      plan(m, s, d, n, p, abort_at);
      cyc = 0; wr_cnt = 0; cs_cnt = 0; first_seen = 1'b0; done_cyc = -1;
      start = 1'b1; mode = m; src_addr = s; dst_addr = d; len = 16'(n); pattern = p;
      abort = (abort_at == 0);
      @(posedge clk); #2;
      start = 1'b0; abort = 1'b0;
      for (int k = 1; k < 3 * n + 20 && exp_q.size() > 0; k++) begin
         abort = (abort_at == k);
         start = (restart_at == k);
         if (restart_at == k) begin
            mode = 1'b0; src_addr = 32'h0; dst_addr = 32'h20; len = 16'd7; pattern = 32'h0;
         end
         @(posedge clk); #2;
      end
      abort = 1'b0; start = 1'b0;
      if (exp_q.size() > 0) begin
         chk("trace_drain_timeout", 32'(exp_q.size()), 32'h0);
         exp_q.delete();
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         ram[i] = 32'd0;
         mdl[i] = 32'd0;
      end
      for (int i = 0; i < 4; i++) begin
         ram[i] = 32'h11 * (i + 1);
         mdl[i] = 32'h11 * (i + 1);
      end

      #23;
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_cs", 32'(cs), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_addr", mem_addr, 32'h0);
      chk("rst_wdata", mem_wdata, 32'h0);
      chk("rst_words", 32'(words_done), 32'h0);
      @(posedge clk); #2;
      resetn = 1'b1;
      check_en = 1'b1;

      issue(1'b1, 32'h0, 32'h40, 4, 32'hA5A5_A5A5, -1, -1);
      chk("fill_done_cyc", 32'(done_cyc), 32'd5);
      chk("fill_wr_cnt", 32'(wr_cnt), 32'd4);
      chk("fill_first_addr", first_wr_addr, 32'h40);
      chk("fill_words", 32'(words_done), 32'd4);
      chk("fill_aborted", 32'(aborted), 32'h0);

      issue(1'b0, 32'h0, 32'h40, 4, 32'h0, -1, -1);
      chk("copy_done_cyc", 32'(done_cyc), 32'd13);
      chk("copy_ram40", ram[16], 32'h11);
      chk("copy_ram44", ram[17], 32'h22);
      chk("copy_ram48", ram[18], 32'h33);
      chk("copy_ram4c", ram[19], 32'h44);

      issue(1'b0, 32'h0, 32'h40, 0, 32'h0, -1, -1);
      chk("len0_done_cyc", 32'(done_cyc), 32'd1);
      chk("len0_cs_cnt", 32'(cs_cnt), 32'd0);
      chk("len0_words", 32'(words_done), 32'd0);

      issue(1'b0, 32'h0, 32'h80, 5, 32'h0, 5, -1);
      chk("abort_done_cyc", 32'(done_cyc), 32'd6);
      chk("abort_wr_cnt", 32'(wr_cnt), 32'd1);
      chk("abort_words", 32'(words_done), 32'd1);
      chk("abort_flag", 32'(aborted), 32'h1);
      chk("abort_ram80", ram[32], 32'h11);

      issue(1'b1, 32'h0, 32'hC0, 2, 32'hC0DE_0001, 0, -1);
      chk("startwins_done_cyc", 32'(done_cyc), 32'd3);
      chk("startwins_aborted", 32'(aborted), 32'h0);
      chk("startwins_words", 32'(words_done), 32'd2);

      issue(1'b1, 32'h0, 32'hFFFF_FFF8, 3, 32'h5A5A_0001, -1, -1);
      chk("wrap_f8", ram[62], 32'h5A5A_0001);
      chk("wrap_fc", ram[63], 32'h5A5A_0001);
      chk("wrap_00", ram[0], 32'h5A5A_0001);

      issue(1'b1, 32'h0, 32'h43, 1, 32'h0BAD_F00D, -1, -1);
      chk("misalign_addr", first_wr_addr, 32'h40);

      issue(1'b1, 32'h0, 32'hD0, 4, 32'h7777_0000, -1, 2);
      chk("busystart_done_cyc", 32'(done_cyc), 32'd5);
      chk("busystart_words", 32'(words_done), 32'd4);
      chk("busystart_wr_cnt", 32'(wr_cnt), 32'd4);

      @(posedge clk); #2;
      abort = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      abort = 1'b0;
      chk("idle_abort_busy", 32'(busy), 32'h0);

      @(posedge clk); #2;
      check_en = 1'b0;
      start = 1'b1; mode = 1'b0; src_addr = 32'h0; dst_addr = 32'h40; len = 16'd4;
      @(posedge clk); #2;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #3;
      resetn = 1'b0;
      #1;
      chk("arst_cs", 32'(cs), 32'h0);
      chk("arst_busy", 32'(busy), 32'h0);
      chk("arst_done", 32'(done), 32'h0);
      chk("arst_addr", mem_addr, 32'h0);
      chk("arst_words", 32'(words_done), 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("arst_no_done", 32'(done), 32'h0);
      end
      @(posedge clk); #2;
      resetn = 1'b1;
      m_wd = 0;
      check_en = 1'b1;
      repeat (4) @(posedge clk);
      #2;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
